// File: rtl/counter_scheduler_pkg.sv
// Shared types and helpers for counter_scheduler: FSM state encoding and the
// counter start-value computation.
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  localparam int START_W = 32;

  // Up-counts start at ~len so that reaching all-ones takes exactly len steps.
  // Callers zero-extend len and truncate the result to their counter width.
  function automatic logic [START_W-1:0] start_value(input logic [START_W-1:0] len,
                                                     input logic               dir);
    return dir ? ~len : len;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit searching
// upward from last+1 with wrap-around.
module rr_arbiter
  import counter_scheduler_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic          valid
);

  int idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one up/down counter between N_REQ requesters, round-robin.
// Optional macro COUNTER_SCHEDULER_ABORT_EN: dropping req mid-interval aborts it.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_len,
  input  logic [N_REQ-1:0]       req_dir,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
`ifdef COUNTER_SCHEDULER_ABORT_EN
  output logic [N_REQ-1:0]       aborted,
`endif
  output logic                   busy,
  output logic                   cnt_load,
  output logic [WIDTH-1:0]       cnt_load_value,
  output logic                   cnt_enable,
  output logic                   cnt_direction,
  input  logic [WIDTH-1:0]       cnt_value,
  input  logic                   cnt_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e     r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IW-1:0]    r_gidx;
  logic [IW-1:0]    r_last;
  logic [WIDTH-1:0] r_len;
  logic             r_dir;

  logic [N_REQ-1:0] w_pick;
  logic             w_valid;
  logic [IW-1:0]    w_pick_idx;
  logic             w_abort;
  logic             w_cnt_value_unused;

  assign w_cnt_value_unused = ^cnt_value;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req),
    .last  (r_last),
    .pick  (w_pick),
    .valid (w_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = IW'(i);
    end
  end

`ifdef COUNTER_SCHEDULER_ABORT_EN
  logic [N_REQ-1:0] r_aborted;
  assign w_abort = ((r_state == LOAD) || (r_state == RUN)) && !req[r_gidx];
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(N_REQ - 1);
`ifdef COUNTER_SCHEDULER_ABORT_EN
      r_aborted <= '0;
`endif
    end else begin
`ifdef COUNTER_SCHEDULER_ABORT_EN
      r_aborted <= '0;
`endif
      if (w_abort) begin
        // Abandoned interval: back to IDLE with no done pulse.
        r_state <= IDLE;
        r_grant <= '0;
        r_last  <= r_gidx;
`ifdef COUNTER_SCHEDULER_ABORT_EN
        r_aborted <= r_grant;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (w_valid) begin
              r_state <= LOAD;
              r_grant <= w_pick;
              r_gidx  <= w_pick_idx;
            end
          end
          LOAD: r_state <= RUN;
          RUN:  if (cnt_done) r_state <= DONE;
          DONE: begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= r_gidx;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Interval parameters captured at grant; only meaningful while busy.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_valid) begin
      r_len <= req_len[w_pick_idx*WIDTH +: WIDTH];
      r_dir <= req_dir[w_pick_idx];
    end
  end

  assign grant          = r_grant;
  assign done           = (r_state == DONE) ? r_grant : '0;
  assign busy           = (r_state != IDLE);
  assign cnt_load       = (r_state == LOAD);
  assign cnt_load_value = (r_state == LOAD) ? WIDTH'(start_value(START_W'(r_len), r_dir)) : '0;
  assign cnt_direction  = busy ? r_dir : 1'b0;
  // Gated by cnt_done combinationally so the counter never passes terminal.
  assign cnt_enable     = (r_state == RUN) && !cnt_done && !w_abort;

endmodule
